// File: rtl/fifo_arb_rr.sv
// fifo_arb_rr: round-robin packet arbiter that drains NCLIENT client FIFOs into
//   one downstream FIFO through a small credit-protected output buffer.
// Latency: a word read in cycle N is buffered at the end of N+1 and can be written
//   downstream in cycle N+2 at the earliest.
// Backpressure: fifo_wrfull stalls buffer pops, and reads stop once the buffered
//   plus in-flight words reach OBUF_DEPTH. Nothing is ever dropped.
//
// Ports:
//   CLK, RESET          clock; synchronous active-high reset
//   c_rdempty / c_rden  per-client empty flags and read enables (one-hot or zero)
//   c_rddata            packed client data, valid the cycle after c_rden
//   fifo_wrfull/_wren   downstream full flag and write strobe
//   fifo_wrdata         downstream data, the head of the output buffer
//   grant               one-hot owner of the packet in progress, zero when idle
//   pkt_done            pulses when the last word of a packet is read
module fifo_arb_rr #(
  parameter int                NCLIENT    = 4,
  parameter int                DWIDTH     = 8,
  parameter logic [DWIDTH-1:0] CNTMASK    = 8'h70,
  parameter int                OBUF_DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NCLIENT-1:0]        c_rdempty,
  output logic [NCLIENT-1:0]        c_rden,
  input  logic [NCLIENT*DWIDTH-1:0] c_rddata,
  input  logic                      fifo_wrfull,
  output logic                      fifo_wren,
  output logic [DWIDTH-1:0]         fifo_wrdata,
  output logic [NCLIENT-1:0]        grant,
  output logic                      pkt_done
);

  // Bit position of the lowest set bit of the count mask.
  function automatic int mask_lsb(input logic [DWIDTH-1:0] m);
    int r;
    r = 0;
    for (int b = DWIDTH - 1; b >= 0; b--) begin
      if (m[b]) r = b;
    end
    return r;
  endfunction

  localparam int CSHIFT = mask_lsb(CNTMASK);
  localparam int IW     = $clog2(NCLIENT);
  localparam int AW     = $clog2(OBUF_DEPTH);
  localparam int CW     = AW + 1;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  state_t              state;
  logic [IW-1:0]       gidx;        // index of the packet owner
  logic [IW-1:0]       last_grant;  // owner of the last completed packet
  logic [NCLIENT-1:0]  grant_q;
  logic [2:0]          remaining;
  logic                rd_vld;      // a read was issued last cycle; data is on c_rddata now

  logic [DWIDTH-1:0]   mem [OBUF_DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [CW-1:0]       count;

  logic [DWIDTH-1:0]   cdata [NCLIENT];
  logic [DWIDTH-1:0]   rd_word;
  logic [2:0]          hdr_cnt;
  logic                credit;
  logic                sel_found;
  logic [IW-1:0]       sel_idx;
  logic [IW-1:0]       cand;
  logic [NCLIENT-1:0]  sel_oh;
  logic [NCLIENT-1:0]  rden_c;
  logic [NCLIENT-1:0]  grant_c;
  logic                done_c;
  logic                push;
  logic                pop;

  for (genvar i = 0; i < NCLIENT; i++) begin : g_split
    assign cdata[i] = c_rddata[i*DWIDTH +: DWIDTH];
  end

  // Only the owner is ever read, so the owner index selects the returning word.
  assign rd_word = cdata[gidx];
  assign hdr_cnt = 3'((rd_word & CNTMASK) >> CSHIFT);

  // Count the word in flight as already occupying a slot so a push never overflows.
  assign credit = (int'(count) + int'(rd_vld)) < OBUF_DEPTH;

  // Round-robin search starting just after the last completed owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NCLIENT; k++) begin
      cand = IW'((int'(last_grant) + k) % NCLIENT);
      if (!sel_found && !c_rdempty[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign sel_oh = NCLIENT'(1) << sel_idx;

  always_comb begin
    rden_c  = '0;
    grant_c = '0;
    done_c  = 1'b0;
    case (state)
      IDLE: begin
        // The winner is visible on grant in the same cycle its header is read.
        if (credit && sel_found) begin
          rden_c  = sel_oh;
          grant_c = sel_oh;
        end
      end
      HDR: begin
        grant_c = grant_q;
        done_c  = (hdr_cnt == 3'd0);
      end
      PAYLOAD: begin
        grant_c = grant_q;
        if (!c_rdempty[gidx] && credit) begin
          rden_c = grant_q;
          done_c = (remaining == 3'd1);
        end
      end
      default: begin
        grant_c = '0;
      end
    endcase
  end

  // Outputs are forced quiet for the whole reset cycle, not just after the edge.
  assign c_rden      = RESET ? '0 : rden_c;
  assign grant       = RESET ? '0 : grant_c;
  assign pkt_done    = RESET ? 1'b0 : done_c;
  assign fifo_wren   = !RESET && (count != '0) && !fifo_wrfull;
  assign fifo_wrdata = mem[rptr];

  assign push = rd_vld;
  assign pop  = fifo_wren;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      gidx       <= '0;
      last_grant <= IW'(NCLIENT - 1);
      grant_q    <= '0;
      remaining  <= '0;
      rd_vld     <= 1'b0;
    end else begin
      rd_vld <= |rden_c;
      case (state)
        IDLE: begin
          if (credit && sel_found) begin
            gidx    <= sel_idx;
            grant_q <= sel_oh;
            state   <= HDR;
          end
        end
        HDR: begin
          if (hdr_cnt == 3'd0) begin
            last_grant <= gidx;
            grant_q    <= '0;
            state      <= IDLE;
          end else begin
            remaining <= hdr_cnt;
            state     <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          // The packet stays owned while the client is empty; there is no timeout.
          if (!c_rdempty[gidx] && credit) begin
            remaining <= remaining - 3'd1;
            if (remaining == 3'd1) begin
              last_grant <= gidx;
              grant_q    <= '0;
              state      <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= rd_word;
  end

endmodule

// File: doc/fifo_arb_rr.md
FIFO_ARB_RR -- requirements
Module: fifo_arb_rr

Interface
REQ-001 Parameter NCLIENT, default 4: number of requesting client FIFOs, 2..8.
REQ-002 Parameter DWIDTH, default 8: data word width.
REQ-003 Parameter CNTMASK, default 8'h70: header mask of 3 contiguous payload-count bits; CSHIFT is the bit index of its lowest set bit.
REQ-004 Parameter OBUF_DEPTH, default 4: output buffer entries, power of two, at least 4.
REQ-005 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-006 RESET  input  1  reset, synchronous and active-high.
REQ-007 c_rdempty  input  NCLIENT  per-client FIFO empty flag.
REQ-008 c_rden  output  NCLIENT  per-client read enable; at most one bit set per cycle.
REQ-009 c_rddata  input  NCLIENT*DWIDTH  packed client read data; client i occupies bits [i*DWIDTH +: DWIDTH]; valid the cycle after the matching c_rden.
REQ-010 fifo_wrfull  input  1  downstream FIFO full.
REQ-011 fifo_wren  output  1  downstream write strobe.
REQ-012 fifo_wrdata  output  DWIDTH  downstream write data.
REQ-013 grant  output  NCLIENT  one-hot owner of the current packet; all zeros when idle.
REQ-014 pkt_done  output  1  one-cycle pulse when the last word of a packet is read from its client.

Function
REQ-015 A packet is 1 header word plus CNT payload words; CNT = (header & CNTMASK) >> CSHIFT, range 0..7.
REQ-016 The FSM has three states: IDLE, HDR and PAYLOAD.
REQ-017 IDLE: if credit is available (REQ-024), select the first non-empty client in round-robin order starting at last_grant+1 modulo NCLIENT, assert its c_rden, load grant, and go to HDR; otherwise stay in IDLE with grant=0.
REQ-018 HDR lasts exactly one cycle with no c_rden asserted; decode CNT from the granted client's c_rddata; CNT=0 pulses pkt_done and goes to IDLE; otherwise load remaining=CNT and go to PAYLOAD.
REQ-019 PAYLOAD: when the granted client is non-empty and credit is available, assert c_rden and decrement remaining; when the read makes remaining 0, pulse pkt_done, update last_grant and go to IDLE.
REQ-020 Packets are atomic: grant is held through PAYLOAD even while the client is empty; there is no timeout and no other client is read.
REQ-021 last_grant updates only on packet completion, including CNT=0 packets.
REQ-022 Every word read, header included, is written into the output buffer in the cycle after its c_rden; order is preserved across packets.
REQ-023 fifo_wren = buffer non-empty AND NOT fifo_wrfull; fifo_wrdata = buffer head (combinational from registered storage); the head pops when fifo_wren is asserted.
REQ-024 Credit: c_rden may be asserted only if (buffer occupancy + reads in flight) < OBUF_DEPTH; this guarantees no overflow, and data is never dropped or duplicated.
REQ-025 A buffer push and a pop in the same cycle leave occupancy unchanged; pointers wrap modulo OBUF_DEPTH.
REQ-026 Latency: a header read in cycle N appears on fifo_wren no earlier than cycle N+2.
REQ-027 Sustained rate is one payload word per cycle while the client is non-empty and fifo_wrfull=0, plus one bubble per packet for HDR.
REQ-028 Simultaneous requests in IDLE are resolved strictly by round-robin order; a client requesting alone is granted immediately.

Reset
REQ-029 While RESET=1: state=IDLE, grant=0, c_rden=0, pkt_done=0, fifo_wren=0, buffer emptied, in-flight read discarded, remaining=0, last_grant=NCLIENT-1 (client 0 has first priority).
REQ-030 Reset mid-packet abandons the packet without completing it; the first cycle after reset deasserts is IDLE.

Verification
REQ-031 Client 0 holds header 8'h30 plus 3 payload words, fifo_wrfull=0 -> 4 reads on c_rden[0]; 4 writes in order, first 2 cycles after the header read; one pkt_done.
REQ-032 All 4 clients each hold one CNT=0 packet at once -> grants in order 0,1,2,3; each grant spans 2 cycles; 4 pkt_done pulses.
REQ-033 Client 1 sends header 8'h20, 1 payload word, then goes empty for 10 cycles while client 2 has data -> grant stays on client 1, client 2 is not read, and the packet finishes after the 2nd payload arrives.
REQ-034 fifo_wrfull=1 during a 7-word payload -> c_rden stops once 4 words are buffered/in flight and no write occurs; after release, all words arrive intact.
REQ-035 RESET=1 for 1 cycle in the middle of PAYLOAD -> next cycle grant=0 and fifo_wren=0; the next packet is granted to client 0 first.
REQ-036 Random multi-client traffic with random fifo_wrfull -> the scoreboard confirms atomic, in-order packets, round-robin fairness, at most one c_rden bit set per cycle, and no buffer overflow.
